// File: rtl/hex_scroll_display.sv
// Scrolls a four-digit window of a loaded 32-bit word across HEX3..HEX0,
// with an adjustable, saturating scroll period and pause/resume.
module hex_scroll_display #(
    parameter int PERIOD_W       = 28,
    parameter int DEFAULT_PERIOD = 25_000_000,
    parameter int STEP           = 2_500_000,
    parameter int MIN_PERIOD     = 2_500_000,
    parameter int MAX_PERIOD     = 100_000_000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [31:0]         data_in,
    input  logic                load,
    input  logic                speedup,
    input  logic                speeddown,
    input  logic                pause,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX0,
    output logic [PERIOD_W-1:0] period,
    output logic [2:0]          pos,
    output logic                running,
    output logic                wrap
);

    // state   | meaning
    // S_IDLE  | no word loaded yet, display blank
    // S_RUN   | counter advances, pos steps every period cycles
    // S_PAUSE | counter and pos frozen, display still shows the window
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    localparam logic [PERIOD_W-1:0] P_DEF  = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] P_STEP = PERIOD_W'(STEP);
    localparam logic [PERIOD_W-1:0] P_MIN  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] P_MAX  = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] LO_SAT = PERIOD_W'(MIN_PERIOD + STEP);
    localparam logic [PERIOD_W-1:0] HI_SAT = PERIOD_W'(MAX_PERIOD - STEP);

    state_t              state, state_nx;
    logic [31:0]         word;
    logic [PERIOD_W-1:0] counter;
    logic                up_q, dn_q;
    logic                up_rise, dn_rise;
    logic                count_en, tick;
    logic [2:0]          i3, i2, i1, i0;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (resetn) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Counting is gated by the live pause level so a pause freezes the
    // counter on the very edge it is first sampled.
    always_comb begin
        state_nx = state;
        count_en = (state == S_RUN) && !pause;
        tick     = count_en && (counter >= period - PERIOD_W'(1));
        up_rise  = speedup & ~up_q;
        dn_rise  = speeddown & ~dn_q;
        case (state)
            S_IDLE:  if (load)   state_nx = pause ? S_PAUSE : S_RUN;
            S_RUN:   if (pause)  state_nx = S_PAUSE;
            S_PAUSE: if (!pause) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            word    <= '0;
            pos     <= '0;
            counter <= '0;
            wrap    <= 1'b0;
            period  <= P_DEF;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            up_q <= speedup;
            dn_q <= speeddown;
            wrap <= 1'b0;
            if (load) begin
                word    <= data_in;
                pos     <= '0;
                counter <= '0;
            end else if (tick) begin
                counter <= '0;
                pos     <= pos + 3'd1;
                wrap    <= (pos == 3'd7);
            end else if (count_en) begin
                counter <= counter + PERIOD_W'(1);
            end
            // Simultaneous up/down edges cancel; period changes never touch the counter.
            if (up_rise && !dn_rise)
                period <= (period <= LO_SAT) ? P_MIN : period - P_STEP;
            else if (dn_rise && !up_rise)
                period <= (period >= HI_SAT) ? P_MAX : period + P_STEP;
        end
    end

    assign i3 = 3'd7 - pos;
    assign i2 = 3'd6 - pos;
    assign i1 = 3'd5 - pos;
    assign i0 = 3'd4 - pos;

    always_ff @(posedge clock) begin
        if (resetn || state == S_IDLE) begin
            HEX3 <= 7'h7F;
            HEX2 <= 7'h7F;
            HEX1 <= 7'h7F;
            HEX0 <= 7'h7F;
        end else begin
            HEX3 <= seg7(word[{i3, 2'b00} +: 4]);
            HEX2 <= seg7(word[{i2, 2'b00} +: 4]);
            HEX1 <= seg7(word[{i1, 2'b00} +: 4]);
            HEX0 <= seg7(word[{i0, 2'b00} +: 4]);
        end
    end

    assign running = (state == S_RUN);

endmodule

// File: tb/tb_hex_scroll_display.sv
// Directed bench for hex_scroll_display with small period parameters
// (default 20, step 4, limits 4..40).
module tb_hex_scroll_display;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic        speedup = 1'b0;
    logic        speeddown = 1'b0;
    logic        pause = 1'b0;
    logic [6:0]  HEX3, HEX2, HEX1, HEX0;
    logic [27:0] period;
    logic [2:0]  pos;
    logic        running;
    logic        wrap;

    int tests = 0;
    int fails = 0;

    localparam logic [27:0] BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [27:0] D1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] D2345 = {7'h24, 7'h30, 7'h19, 7'h12};
    localparam logic [27:0] D5678 = {7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [27:0] D8123 = {7'h00, 7'h79, 7'h24, 7'h30};
    localparam logic [27:0] D6781 = {7'h02, 7'h78, 7'h00, 7'h79};
    localparam logic [27:0] DDEAD = {7'h21, 7'h06, 7'h08, 7'h21};

    hex_scroll_display #(
        .PERIOD_W(28), .DEFAULT_PERIOD(20), .STEP(4), .MIN_PERIOD(4), .MAX_PERIOD(40)
    ) dut (
        .clock(clock), .resetn(resetn), .data_in(data_in), .load(load),
        .speedup(speedup), .speeddown(speeddown), .pause(pause),
        .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
        .period(period), .pos(pos), .running(running), .wrap(wrap)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b1;
        step(2);
        resetn = 1'b0;
        tests++; if ({HEX3, HEX2, HEX1, HEX0} !== BLANK) begin fails++; $display("FAIL reset_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, BLANK); end
        tests++; if (pos !== 3'd0) begin fails++; $display("FAIL reset_pos: got %0d expected 0", pos); end
        tests++; if (period !== 28'd20) begin fails++; $display("FAIL reset_period: got %0d expected 20", period); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b expected 0", running); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        step(3);
        tests++; if ({HEX3, HEX2, HEX1, HEX0} !== BLANK) begin fails++; $display("FAIL idle_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, BLANK); end
    endtask

    task automatic test_scroll;
        logic [2:0]  pexp;
        logic        wexp;
        logic [27:0] hexp;
        data_in = 32'h1234_5678;
        load = 1'b1;
        step(1);
        load = 1'b0;
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL scroll_running: got %b expected 1", running); end
        tests++; if (pos !== 3'd0) begin fails++; $display("FAIL scroll_pos_load: got %0d expected 0", pos); end
        for (int t = 1; t <= 161; t++) begin
            step(1);
            pexp = 3'((t / 20) % 8);
            wexp = (t == 160);
            tests++; if (pos !== pexp) begin fails++; $display("FAIL scroll_pos t=%0d: got %0d expected %0d", t, pos, pexp); end
            tests++; if (wrap !== wexp) begin fails++; $display("FAIL scroll_wrap t=%0d: got %b expected %b", t, wrap, wexp); end
            if (t == 1 || t == 21 || t == 81 || t == 141) begin
                hexp = (t == 1) ? D1234 : (t == 21) ? D2345 : (t == 81) ? D5678 : D8123;
                tests++; if ({HEX3, HEX2, HEX1, HEX0} !== hexp) begin fails++; $display("FAIL scroll_hex t=%0d: got %h expected %h", t, {HEX3, HEX2, HEX1, HEX0}, hexp); end
            end
        end
    endtask

    task automatic test_speed;
        int up_exp [5] = '{16, 12, 8, 4, 4};
        int dexp;
        for (int i = 0; i < 5; i++) begin
            speedup = 1'b1; step(1);
            tests++; if (period !== 28'(up_exp[i])) begin fails++; $display("FAIL speedup_%0d: got %0d expected %0d", i, period, up_exp[i]); end
            speedup = 1'b0; step(1);
        end
        for (int i = 0; i < 10; i++) begin
            dexp = (4 + 4 * (i + 1) > 40) ? 40 : 4 + 4 * (i + 1);
            speeddown = 1'b1; step(1);
            tests++; if (period !== 28'(dexp)) begin fails++; $display("FAIL speeddown_%0d: got %0d expected %0d", i, period, dexp); end
            speeddown = 1'b0; step(1);
        end
        speedup = 1'b1;
        step(1);
        tests++; if (period !== 28'd36) begin fails++; $display("FAIL held_first: got %0d expected 36", period); end
        step(49);
        tests++; if (period !== 28'd36) begin fails++; $display("FAIL held_end: got %0d expected 36", period); end
        speedup = 1'b0;
        step(1);
        tests++; if (period !== 28'd36) begin fails++; $display("FAIL held_release: got %0d expected 36", period); end
    endtask

    task automatic test_both_edges;
        speedup = 1'b1; speeddown = 1'b1;
        step(1);
        tests++; if (period !== 28'd36) begin fails++; $display("FAIL both_edges: got %0d expected 36", period); end
        speedup = 1'b0; speeddown = 1'b0;
        step(1);
        speeddown = 1'b1; step(1);
        tests++; if (period !== 28'd40) begin fails++; $display("FAIL after_both: got %0d expected 40", period); end
        speeddown = 1'b0; step(1);
    endtask

    task automatic test_pause;
        resetn = 1'b1; step(1); resetn = 1'b0;
        data_in = 32'h1234_5678;
        load = 1'b1; step(1); load = 1'b0;
        step(7);
        pause = 1'b1;
        step(1);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL pause_running: got %b expected 0", running); end
        for (int k = 1; k < 30; k++) begin
            step(1);
            tests++; if (pos !== 3'd0) begin fails++; $display("FAIL pause_pos k=%0d: got %0d expected 0", k, pos); end
        end
        pause = 1'b0;
        step(1);
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL resume_running: got %b expected 1", running); end
        step(12);
        tests++; if (pos !== 3'd0) begin fails++; $display("FAIL resume_early: got %0d expected 0", pos); end
        step(1);
        tests++; if (pos !== 3'd1) begin fails++; $display("FAIL resume_step: got %0d expected 1", pos); end
    endtask

    task automatic test_load_priority;
        step(139);
        tests++; if (pos !== 3'd7) begin fails++; $display("FAIL prio_pre_pos: got %0d expected 7", pos); end
        data_in = 32'hDEAD_BEEF;
        load = 1'b1; step(1); load = 1'b0;
        tests++; if (pos !== 3'd0) begin fails++; $display("FAIL prio_pos: got %0d expected 0", pos); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL prio_wrap: got %b expected 0", wrap); end
        step(1);
        tests++; if ({HEX3, HEX2, HEX1, HEX0} !== DDEAD) begin fails++; $display("FAIL prio_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, DDEAD); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL prio_wrap_late: got %b expected 0", wrap); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            speedup = 1'b1; step(1); speedup = 1'b0; step(1);
        end
        tests++; if (period !== 28'd8) begin fails++; $display("FAIL mid_period: got %0d expected 8", period); end
        data_in = 32'h1234_5678;
        load = 1'b1; step(1); load = 1'b0;
        step(40);
        tests++; if (pos !== 3'd5) begin fails++; $display("FAIL mid_pos: got %0d expected 5", pos); end
        step(1);
        tests++; if ({HEX3, HEX2, HEX1, HEX0} !== D6781) begin fails++; $display("FAIL mid_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, D6781); end
        resetn = 1'b1; step(1); resetn = 1'b0;
        tests++; if (pos !== 3'd0) begin fails++; $display("FAIL rst_pos: got %0d expected 0", pos); end
        tests++; if (period !== 28'd20) begin fails++; $display("FAIL rst_period: got %0d expected 20", period); end
        tests++; if ({HEX3, HEX2, HEX1, HEX0} !== BLANK) begin fails++; $display("FAIL rst_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, BLANK); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL rst_running: got %b expected 0", running); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL rst_wrap: got %b expected 0", wrap); end
        for (int k = 0; k < 30; k++) begin
            step(1);
            tests++; if (pos !== 3'd0 || running !== 1'b0) begin fails++; $display("FAIL rst_idle k=%0d: got pos %0d running %b expected 0 0", k, pos, running); end
        end
        tests++; if ({HEX3, HEX2, HEX1, HEX0} !== BLANK) begin fails++; $display("FAIL rst_idle_hex: got %h expected %h", {HEX3, HEX2, HEX1, HEX0}, BLANK); end
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_speed();
        test_both_edges();
        test_pause();
        test_load_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
